// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS datapath: hazard FSM states,
// the NOP encoding, and the register-0 constant used by hazard and forwarding logic.
package pipeline_pkg;

  typedef enum logic {
    NO_HAZ  = 1'b0,
    BR_WAIT = 1'b1
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use stall and jump/branch penalty sequencing between IF/ID and ID/EX,
// with a saturating lost-cycle counter.
//
// state   | meaning
// NO_HAZ  | normal flow; detect load-use, branch or jump in ID
// BR_WAIT | branch now in EX; PC mux takes the outcome, ID is flushed again
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             ID_Branch,
  input  logic [4:0]       EX_Rw,
  input  logic             EX_MemRead,
  output logic             PCWrite,
  output logic             IFWrite,
  output logic             IFFlush,
  output logic             Bubble,
  output logic             BranchResolve,
  output logic [CNT_W-1:0] StallCount
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  assign load_use = EX_MemRead && (EX_Rw != REG_ZERO) &&
                    ((ID_UseRs && (ID_Rs == EX_Rw)) ||
                     (ID_UseRt && (ID_Rt == EX_Rw)));

  always_comb begin
    state_d       = state_q;
    PCWrite       = 1'b1;
    IFWrite       = 1'b1;
    IFFlush       = 1'b0;
    Bubble        = 1'b0;
    BranchResolve = 1'b0;

    case (state_q)
      NO_HAZ: begin
        if (load_use) begin
          PCWrite = 1'b0;
          IFWrite = 1'b0;
          Bubble  = 1'b1;
        end else if (ID_Branch) begin
          PCWrite = 1'b0;
          IFWrite = 1'b0;
          IFFlush = 1'b1;
          state_d = BR_WAIT;
        end else if (ID_Jump) begin
          IFWrite = 1'b0;
          IFFlush = 1'b1;
        end
      end
      BR_WAIT: begin
        // ID holds the flushed NOP, so its fields are deliberately ignored here
        BranchResolve = 1'b1;
        IFWrite       = 1'b0;
        IFFlush       = 1'b1;
        state_d       = NO_HAZ;
      end
      default: state_d = NO_HAZ;
    endcase

    if (!Reset_L) begin
      PCWrite       = 1'b0;
      IFWrite       = 1'b0;
      IFFlush       = 1'b0;
      Bubble        = 1'b1;
      BranchResolve = 1'b0;
      state_d       = NO_HAZ;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((Bubble || IFFlush) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= NO_HAZ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: control outputs checked mid-cycle, the lost-cycle
// counter checked just after each rising edge, with a 4-bit counter to reach saturation.
module tb_hazard_unit;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Reset_L;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rw;
  logic             ID_UseRs, ID_UseRt, ID_Jump, ID_Branch, EX_MemRead;
  logic             PCWrite, IFWrite, IFFlush, Bubble, BranchResolve;
  logic [CNT_W-1:0] StallCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Jump(ID_Jump), .ID_Branch(ID_Branch),
    .EX_Rw(EX_Rw), .EX_MemRead(EX_MemRead),
    .PCWrite(PCWrite), .IFWrite(IFWrite), .IFFlush(IFFlush), .Bubble(Bubble),
    .BranchResolve(BranchResolve), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_Jump = 1'b0; ID_Branch = 1'b0; EX_Rw = 5'd0; EX_MemRead = 1'b0;
  endtask

  // exp_ctrl = {PCWrite, IFWrite, IFFlush, Bubble, BranchResolve}
  task automatic cyc(input string tag, input logic [4:0] exp_ctrl);
    #1;
    check({tag, "_ctrl"}, {27'd0, PCWrite, IFWrite, IFFlush, Bubble, BranchResolve},
          {27'd0, exp_ctrl});
    @(posedge CLK);
    if (!Reset_L) exp_cnt = 0;
    else if ((exp_ctrl[2] || exp_ctrl[1]) && exp_cnt < 15) exp_cnt++;
    #1;
    check({tag, "_cnt"}, {28'd0, StallCount}, exp_cnt);
    @(negedge CLK);
  endtask

  task automatic set_load_use(input logic [4:0] rw);
    EX_MemRead = 1'b1; EX_Rw = rw; ID_Rs = rw; ID_UseRs = 1'b1;
  endtask

  initial begin
    clear_inputs();
    Reset_L = 1'b0;
    @(negedge CLK);

    cyc("reset0", 5'b00010);
    cyc("reset1", 5'b00010);

    Reset_L = 1'b1;
    cyc("idle", 5'b11000);

    set_load_use(5'd8);
    cyc("lu_rs", 5'b00010);
    clear_inputs();
    cyc("lu_after", 5'b11000);

    set_load_use(5'd0);
    cyc("lu_r0", 5'b11000);
    clear_inputs();

    EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rt = 5'd5; ID_UseRt = 1'b1;
    cyc("lu_rt", 5'b00010);
    ID_UseRt = 1'b0;
    cyc("rt_unused", 5'b11000);
    EX_MemRead = 1'b0; ID_UseRt = 1'b1;
    cyc("not_load", 5'b11000);
    clear_inputs();

    ID_Branch = 1'b1;
    cyc("br_id", 5'b00100);
    ID_Branch = 1'b0; ID_Jump = 1'b1; set_load_use(5'd3);
    cyc("br_wait", 5'b10101);
    clear_inputs();
    cyc("br_after", 5'b11000);

    ID_Jump = 1'b1;
    cyc("jump", 5'b10100);
    clear_inputs();
    cyc("jump_after", 5'b11000);

    ID_Branch = 1'b1; set_load_use(5'd9);
    cyc("prio_lu", 5'b00010);
    EX_MemRead = 1'b0;
    cyc("prio_br", 5'b00100);
    clear_inputs();
    cyc("prio_wait", 5'b10101);
    cyc("prio_after", 5'b11000);

    set_load_use(5'd12);
    for (int i = 0; i < 20; i++) cyc("sat", 5'b00010);
    check("sat_final", {28'd0, StallCount}, 32'd15);
    clear_inputs();

    ID_Branch = 1'b1;
    cyc("abort_br", 5'b00100);
    clear_inputs();
    Reset_L = 1'b0;
    cyc("abort_rst", 5'b00010);
    Reset_L = 1'b1;
    cyc("abort_after", 5'b11000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS datapath, sitting between the IF/ID register and the ID/EX register, directly upstream of the EX-stage forwarding logic. It detects load-use hazards that forwarding cannot cover, sequences control-transfer penalties for jumps (resolved in ID) and branches (resolved in EX), and drives the PC and IF/ID write enables, the IF/ID flush, and the ID/EX bubble insert. A saturating counter records lost cycles for performance checks.

## Interface
- CNT_W, 16, width of the lost-cycle counter
- CLK  in  1  pipeline clock; all state updates on rising edge
- Reset_L  in  1  synchronous, active-low reset
- ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID
- ID_UseRs, ID_UseRt  in  1 each  instruction in ID actually reads Rs / Rt
- ID_Jump  in  1  instruction in ID is j/jal/jr
- ID_Branch  in  1  instruction in ID is beq/bne
- EX_Rw  in  5  destination register of the instruction in EX
- EX_MemRead  in  1  instruction in EX is a load
- PCWrite  out  1  PC register load enable
- IFWrite  out  1  IF/ID register load enable
- IFFlush  out  1  load NOP into IF/ID this cycle (overrides IFWrite)
- Bubble  out  1  zero all ID/EX control bits this cycle
- BranchResolve  out  1  branch is in EX; datapath PC mux uses the branch outcome
- StallCount  out  CNT_W  saturating count of cycles with Bubble or IFFlush asserted

## Operation
- States: NO_HAZ, BR_WAIT. Control outputs are Mealy: a function of the state and the current inputs.
- LoadUse = EX_MemRead & (EX_Rw != 0) & ((ID_UseRs & ID_Rs == EX_Rw) | (ID_UseRt & ID_Rt == EX_Rw)).
- NO_HAZ, priority order:
  - LoadUse: PCWrite=0, IFWrite=0, IFFlush=0, Bubble=1. Stay in NO_HAZ.
  - Else ID_Branch: PCWrite=0, IFWrite=0, IFFlush=1, Bubble=0. Go to BR_WAIT.
  - Else ID_Jump: PCWrite=1 (PC loads the jump target), IFWrite=0, IFFlush=1, Bubble=0. Stay in NO_HAZ.
  - Else: PCWrite=1, IFWrite=1, IFFlush=0, Bubble=0.
- BR_WAIT: BranchResolve=1, PCWrite=1, IFWrite=0, IFFlush=1, Bubble=0. Go to NO_HAZ unconditionally. ID inputs are ignored because ID holds a flushed NOP.
- BranchResolve=0 in NO_HAZ.
- StallCount increments by 1 in every cycle where (Bubble | IFFlush). It holds at 2^CNT_W-1 once reached (no wrap).

## Timing
- Reset (Reset_L=0 at a rising edge): state becomes NO_HAZ and StallCount becomes 0.
- While Reset_L=0, outputs are forced: PCWrite=0, IFWrite=0, IFFlush=0, Bubble=1, BranchResolve=0.
- Reset asserted during BR_WAIT aborts the branch sequence; there is no resolve cycle after reset.
- Load-use penalty is exactly 1 cycle. The next cycle the load is in MEM, and forwarding supplies the value.
- Jump penalty is 1 flushed cycle.
- Branch penalty is 2 flushed cycles: the ID cycle plus the BR_WAIT cycle. The PC is correct on the cycle after BR_WAIT.
- LoadUse together with ID_Branch: the stall wins. The branch is re-evaluated next cycle, still in ID, and then enters BR_WAIT.
- EX_Rw = 0 never produces a stall.
- A stall decision in the same cycle that StallCount saturates keeps the count at its maximum.

## Structure
- Shared package pipeline_pkg holds:
  - the state enum {NO_HAZ, BR_WAIT};
  - the NOP encoding 32'h0000_0000;
  - the register-0 constant, used here and by the forwarding logic.
- Single module, no sub-modules. The saturating counter stays inline.

## Test plan
- Reset: hold Reset_L=0 for 2 cycles, then release -> outputs PCWrite=0, Bubble=1 while in reset; StallCount=0; then PCWrite=1, IFWrite=1 with no hazard.
- Load-use: EX_MemRead=1, EX_Rw=8, ID_Rs=8, ID_UseRs=1 -> exactly one cycle with PCWrite=0, IFWrite=0, Bubble=1; StallCount=1. Repeat with EX_Rw=0 -> no stall.
- Branch: ID_Branch=1 for one cycle -> that cycle IFFlush=1, PCWrite=0. Next cycle BranchResolve=1, PCWrite=1, IFFlush=1. Following cycle normal. StallCount increases by 2.
- Jump: ID_Jump=1 -> one cycle with PCWrite=1, IFFlush=1; state stays NO_HAZ; StallCount increases by 1.
- Priority: LoadUse and ID_Branch together -> cycle 1 Bubble=1 only; cycle 2 (LoadUse cleared, branch still present) IFFlush=1, then BR_WAIT.
- Saturation and reset abort: with CNT_W=4, drive 20 load-use stalls -> StallCount holds at 15. Assert reset in BR_WAIT -> BranchResolve=0 and state NO_HAZ next cycle.
